// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
//   Shares one RTC bus-cycle engine among three burst sources: user write-all,
//   user read-all and a periodic refresh read. Each burst is an ordered series of
//   single-register transactions, launched one at a time over eng_start/eng_done.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   wr_req, rd_req  level burst requests, held until the matching ack
//   wr_ack, rd_ack  one-cycle pulse when a user burst finishes or aborts
//   refresh_done    one-cycle pulse when a refresh burst finishes or aborts
//   eng_start       one-cycle pulse launching one engine transaction
//   eng_w_r         transaction type (1 = write, 0 = read), valid while busy
//   eng_done        one-cycle completion pulse from the engine
//   reg_idx         register index of the current transaction, valid while busy
//   busy            high from burst acceptance through the ack cycle
//   timeout_err     sticky watchdog abort flag, cleared when a burst is accepted
module rtc_bus_scheduler #(
    parameter int unsigned N_REGS         = 10,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned TIMEOUT        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_ack,
    output logic             rd_ack,
    output logic             refresh_done,
    output logic             eng_start,
    output logic             eng_w_r,
    input  logic             eng_done,
    output logic [IDX_W-1:0] reg_idx,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned RT_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] IDX_CMD     = IDX_W'(N_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_RD = IDX_W'(N_REGS - 2);
    localparam logic [RT_W-1:0]  RT_MAX      = RT_W'(REFRESH_CYCLES - 1);
    // Compared before the increment, so the abort fires as the count reaches TIMEOUT-1.
    localparam logic [WD_W-1:0]  WD_LIMIT    = WD_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
    typedef enum logic [1:0] {KindWr, KindRd, KindRf} kind_e;

    state_e            state_q;
    kind_e             kind_q;
    logic [RT_W-1:0]   rt_cnt_q;
    logic              refresh_pending_q;
    logic [WD_W-1:0]   wdog_q;

    logic              tick;
    logic              rd_accept;
    logic              last_xfer;
    logic [IDX_W-1:0]  next_idx;

    assign tick      = (rt_cnt_q == RT_MAX);
    // A user read also satisfies a pending refresh, so both kinds clear it.
    assign rd_accept = (state_q == StIdle) && !wr_req && (rd_req || refresh_pending_q);
    assign last_xfer = (kind_q == KindWr) ? (reg_idx == IDX_CMD) : (reg_idx == IDX_LAST_RD);
    // Read bursts start at the command register, then wrap to 0.
    assign next_idx  = (kind_q != KindWr && reg_idx == IDX_CMD) ? '0 : reg_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= StIdle;
            kind_q            <= KindWr;
            rt_cnt_q          <= '0;
            refresh_pending_q <= 1'b0;
            wdog_q            <= '0;
            wr_ack            <= 1'b0;
            rd_ack            <= 1'b0;
            refresh_done      <= 1'b0;
            eng_start         <= 1'b0;
            eng_w_r           <= 1'b0;
            reg_idx           <= '0;
            busy              <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            rt_cnt_q     <= tick ? '0 : rt_cnt_q + RT_W'(1);
            eng_start    <= 1'b0;
            wr_ack       <= 1'b0;
            rd_ack       <= 1'b0;
            refresh_done <= 1'b0;

            // Set wins over clear; repeated ticks collapse into one pending flag.
            if (tick) begin
                refresh_pending_q <= 1'b1;
            end else if (rd_accept) begin
                refresh_pending_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (wr_req || rd_req || refresh_pending_q) begin
                        state_q     <= StIssue;
                        busy        <= 1'b1;
                        eng_start   <= 1'b1;
                        eng_w_r     <= 1'b1;
                        timeout_err <= 1'b0;
                        if (wr_req) begin
                            kind_q  <= KindWr;
                            reg_idx <= '0;
                        end else begin
                            kind_q  <= rd_req ? KindRd : KindRf;
                            reg_idx <= IDX_CMD;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    wdog_q  <= '0;
                end
                StWait: begin
                    if (eng_done) begin
                        if (last_xfer) begin
                            state_q      <= StDone;
                            wr_ack       <= (kind_q == KindWr);
                            rd_ack       <= (kind_q == KindRd);
                            refresh_done <= (kind_q == KindRf);
                        end else begin
                            state_q   <= StIssue;
                            eng_start <= 1'b1;
                            reg_idx   <= next_idx;
                            eng_w_r   <= (kind_q == KindWr);
                        end
                    end else if (wdog_q == WD_LIMIT) begin
                        state_q      <= StDone;
                        timeout_err  <= 1'b1;
                        wr_ack       <= (kind_q == KindWr);
                        rd_ack       <= (kind_q == KindRd);
                        refresh_done <= (kind_q == KindRf);
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    eng_w_r <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler
//   Directed bench. Instance a (TIMEOUT 8, refresh effectively off) covers user
//   bursts, watchdog abort and mid-burst reset; instance b (REFRESH_CYCLES 50)
//   covers refresh scheduling. Each has an engine model answering 3 cycles after
//   eng_start.
module tb_rtc_bus_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic reset_a = 1'b1, wr_req_a = 1'b0, rd_req_a = 1'b0, en_a = 1'b1;
    logic wr_ack_a, rd_ack_a, refresh_done_a, eng_start_a, eng_w_r_a, eng_done_a;
    logic busy_a, timeout_err_a;
    logic [3:0] reg_idx_a;
    logic [2:0] pipe_a;

    logic reset_b = 1'b1, wr_req_b = 1'b0, rd_req_b = 1'b0;
    logic wr_ack_b, rd_ack_b, refresh_done_b, eng_start_b, eng_w_r_b, eng_done_b;
    logic busy_b, timeout_err_b;
    logic [3:0] reg_idx_b;
    logic [2:0] pipe_b;

    rtc_bus_scheduler #(
        .N_REGS(10), .IDX_W(4), .REFRESH_CYCLES(100000), .TIMEOUT(8)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .wr_req(wr_req_a), .rd_req(rd_req_a),
        .wr_ack(wr_ack_a), .rd_ack(rd_ack_a), .refresh_done(refresh_done_a),
        .eng_start(eng_start_a), .eng_w_r(eng_w_r_a), .eng_done(eng_done_a),
        .reg_idx(reg_idx_a), .busy(busy_a), .timeout_err(timeout_err_a)
    );

    rtc_bus_scheduler #(
        .N_REGS(10), .IDX_W(4), .REFRESH_CYCLES(50), .TIMEOUT(64)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .wr_req(wr_req_b), .rd_req(rd_req_b),
        .wr_ack(wr_ack_b), .rd_ack(rd_ack_b), .refresh_done(refresh_done_b),
        .eng_start(eng_start_b), .eng_w_r(eng_w_r_b), .eng_done(eng_done_b),
        .reg_idx(reg_idx_b), .busy(busy_b), .timeout_err(timeout_err_b)
    );

    // Engine models: eng_done 3 cycles after eng_start, cleared by the shared reset.
    always @(posedge clk or posedge reset_a)
        if (reset_a) pipe_a <= '0;
        else         pipe_a <= {pipe_a[1:0], eng_start_a & en_a};
    assign eng_done_a = pipe_a[2];

    always @(posedge clk or posedge reset_b)
        if (reset_b) pipe_b <= '0;
        else         pipe_b <= {pipe_b[1:0], eng_start_b};
    assign eng_done_b = pipe_b[2];

    // Event logs: start cycle/index/type, and ack cycles per kind.
    int sa_cyc[$], sa_idx[$], sa_wr[$], wa_cyc[$], ra_cyc[$], fa_cyc[$];
    int sb_cyc[$], sb_idx[$], sb_wr[$], wb_cyc[$], rb_cyc[$], fb_cyc[$];

    always @(negedge clk) begin
        if (eng_start_a) begin
            sa_cyc.push_back(cyc); sa_idx.push_back(int'(reg_idx_a));
            sa_wr.push_back(int'(eng_w_r_a));
        end
        if (wr_ack_a)       wa_cyc.push_back(cyc);
        if (rd_ack_a)       ra_cyc.push_back(cyc);
        if (refresh_done_a) fa_cyc.push_back(cyc);
        if (eng_start_b) begin
            sb_cyc.push_back(cyc); sb_idx.push_back(int'(reg_idx_b));
            sb_wr.push_back(int'(eng_w_r_b));
        end
        if (wr_ack_b)       wb_cyc.push_back(cyc);
        if (rd_ack_b)       rb_cyc.push_back(cyc);
        if (refresh_done_b) fb_cyc.push_back(cyc);
    end

    function automatic int qat(input int q[$], input int k);
        if (k >= 0 && k < q.size()) return q[k];
        return -1;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Runs until every raised request on a has been acked, then one more cycle.
    task automatic drive_a(input int budget);
        int n = 0;
        while ((wr_req_a || rd_req_a) && n < budget) begin
            @(negedge clk); n++;
            if (wr_ack_a) wr_req_a = 1'b0;
            if (rd_ack_a) rd_req_a = 1'b0;
        end
        n_checks++;
        if (wr_req_a || rd_req_a) begin
            $display("FAIL drive_a_budget: acks missing after %0d cycles, want within %0d", n, budget);
            wr_req_a = 1'b0; rd_req_a = 1'b0;
        end else n_pass++;
        @(negedge clk);
    endtask

    task automatic drive_b(input int budget);
        int n = 0;
        while ((wr_req_b || rd_req_b) && n < budget) begin
            @(negedge clk); n++;
            if (wr_ack_b) wr_req_b = 1'b0;
            if (rd_ack_b) rd_req_b = 1'b0;
        end
        n_checks++;
        if (wr_req_b || rd_req_b) begin
            $display("FAIL drive_b_budget: acks missing after %0d cycles, want within %0d", n, budget);
            wr_req_b = 1'b0; rd_req_b = 1'b0;
        end else n_pass++;
        @(negedge clk);
    endtask

    // Fresh reset of b; r0 is the cycle of release, so edge n lands at cycle r0+n.
    task automatic pulse_reset_b(output int r0);
        @(negedge clk); reset_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        r0 = cyc;
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wr_ack_a, rd_ack_a, refresh_done_a, eng_start_a, eng_w_r_a, busy_a, timeout_err_a} !== 7'd0)
            $display("FAIL reset_ctrl_a: got %b want 0000000", {wr_ack_a, rd_ack_a,
                     refresh_done_a, eng_start_a, eng_w_r_a, busy_a, timeout_err_a});
        else n_pass++;
        n_checks++;
        if (reg_idx_a !== 4'd0) $display("FAIL reset_idx_a: got %0d want 0", reg_idx_a);
        else n_pass++;
        n_checks++;
        if ({busy_b, eng_start_b, refresh_done_b, reg_idx_b} !== 7'd0)
            $display("FAIL reset_b: got %b want 0", {busy_b, eng_start_b, refresh_done_b, reg_idx_b});
        else n_pass++;
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || eng_start_a !== 1'b0)
            $display("FAIL idle_no_req: busy/start %b%b want 00", busy_a, eng_start_a);
        else n_pass++;
    endtask

    task automatic test_write_burst();
        int bs, bw, br, t0;
        bs = sa_cyc.size(); bw = wa_cyc.size(); br = ra_cyc.size();
        @(negedge clk); t0 = cyc; wr_req_a = 1'b1;
        drive_a(200);
        n_checks++;
        if (busy_a !== 1'b0) $display("FAIL wr_busy_after_ack: got %b want 0", busy_a);
        else n_pass++;
        n_checks++;
        if (sa_cyc.size() - bs != 10) $display("FAIL wr_count: got %0d want 10", sa_cyc.size() - bs);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (qat(sa_idx, bs + i) != i || qat(sa_wr, bs + i) != 1 || qat(sa_cyc, bs + i) != t0 + 1 + 4 * i)
                $display("FAIL wr_xfer%0d: idx/w_r/cycle got %0d/%0d/%0d want %0d/1/%0d", i,
                         qat(sa_idx, bs + i), qat(sa_wr, bs + i), qat(sa_cyc, bs + i), i, t0 + 1 + 4 * i);
            else n_pass++;
        end
        n_checks++;
        if (wa_cyc.size() - bw != 1 || qat(wa_cyc, bw) != t0 + 41 || ra_cyc.size() != br)
            $display("FAIL wr_ack: count/cycle/rd_acks got %0d/%0d/%0d want 1/%0d/0",
                     wa_cyc.size() - bw, qat(wa_cyc, bw), ra_cyc.size() - br, t0 + 41);
        else n_pass++;
    endtask

    task automatic test_read_burst();
        int bs, bw, br, t0;
        bs = sa_cyc.size(); bw = wa_cyc.size(); br = ra_cyc.size();
        @(negedge clk); t0 = cyc; rd_req_a = 1'b1;
        drive_a(200);
        n_checks++;
        if (sa_cyc.size() - bs != 10) $display("FAIL rd_count: got %0d want 10", sa_cyc.size() - bs);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (qat(sa_idx, bs + i) != (i == 0 ? 9 : i - 1) || qat(sa_wr, bs + i) != (i == 0 ? 1 : 0)
                || qat(sa_cyc, bs + i) != t0 + 1 + 4 * i)
                $display("FAIL rd_xfer%0d: idx/w_r/cycle got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         qat(sa_idx, bs + i), qat(sa_wr, bs + i), qat(sa_cyc, bs + i),
                         i == 0 ? 9 : i - 1, i == 0 ? 1 : 0, t0 + 1 + 4 * i);
            else n_pass++;
        end
        n_checks++;
        if (ra_cyc.size() - br != 1 || qat(ra_cyc, br) != t0 + 41 || wa_cyc.size() != bw)
            $display("FAIL rd_ack: count/cycle/wr_acks got %0d/%0d/%0d want 1/%0d/0",
                     ra_cyc.size() - br, qat(ra_cyc, br), wa_cyc.size() - bw, t0 + 41);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bs, bw, br, t0, ei, ew, ec;
        bs = sa_cyc.size(); bw = wa_cyc.size(); br = ra_cyc.size();
        @(negedge clk); t0 = cyc; wr_req_a = 1'b1; rd_req_a = 1'b1;
        drive_a(300);
        n_checks++;
        if (sa_cyc.size() - bs != 20) $display("FAIL b2b_count: got %0d want 20", sa_cyc.size() - bs);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) begin
                ei = i; ew = 1; ec = t0 + 1 + 4 * i;
            end else begin
                ei = (i == 10) ? 9 : i - 11; ew = (i == 10) ? 1 : 0; ec = t0 + 43 + 4 * (i - 10);
            end
            n_checks++;
            if (qat(sa_idx, bs + i) != ei || qat(sa_wr, bs + i) != ew || qat(sa_cyc, bs + i) != ec)
                $display("FAIL b2b_xfer%0d: idx/w_r/cycle got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         qat(sa_idx, bs + i), qat(sa_wr, bs + i), qat(sa_cyc, bs + i), ei, ew, ec);
            else n_pass++;
        end
        n_checks++;
        if (qat(wa_cyc, bw) != t0 + 41 || qat(ra_cyc, br) != t0 + 83)
            $display("FAIL b2b_acks: wr/rd cycle got %0d/%0d want %0d/%0d",
                     qat(wa_cyc, bw), qat(ra_cyc, br), t0 + 41, t0 + 83);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int bs, bw, t0, t1;
        en_a = 1'b0;
        bs = sa_cyc.size(); bw = wa_cyc.size();
        @(negedge clk); t0 = cyc; wr_req_a = 1'b1;
        drive_a(100);
        n_checks++;
        if (qat(wa_cyc, bw) != t0 + 9 || sa_cyc.size() - bs != 1)
            $display("FAIL tout_ack: ack cycle/starts got %0d/%0d want %0d/1",
                     qat(wa_cyc, bw), sa_cyc.size() - bs, t0 + 9);
        else n_pass++;
        n_checks++;
        if (timeout_err_a !== 1'b1 || busy_a !== 1'b0)
            $display("FAIL tout_sticky: err/busy got %b%b want 10", timeout_err_a, busy_a);
        else n_pass++;
        en_a = 1'b1;
        bw = wa_cyc.size();
        @(negedge clk); t1 = cyc; wr_req_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (eng_start_a !== 1'b1 || timeout_err_a !== 1'b0 || reg_idx_a !== 4'd0)
            $display("FAIL tout_clear: start/err/idx got %b/%b/%0d want 1/0/0",
                     eng_start_a, timeout_err_a, reg_idx_a);
        else n_pass++;
        drive_a(200);
        n_checks++;
        if (qat(wa_cyc, bw) != t1 + 41 || timeout_err_a !== 1'b0)
            $display("FAIL tout_recover: ack cycle/err got %0d/%b want %0d/0",
                     qat(wa_cyc, bw), timeout_err_a, t1 + 41);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int bs, bw, t0, t1;
        bw = wa_cyc.size();
        @(negedge clk); t0 = cyc; wr_req_a = 1'b1;
        wait_until(t0 + 18);
        n_checks++;
        if (reg_idx_a !== 4'd4 || busy_a !== 1'b1 || eng_start_a !== 1'b0)
            $display("FAIL rst_mid_pre: idx/busy/start got %0d/%b/%b want 4/1/0",
                     reg_idx_a, busy_a, eng_start_a);
        else n_pass++;
        reset_a = 1'b1; wr_req_a = 1'b0;
        #1;
        n_checks++;
        if ({wr_ack_a, rd_ack_a, refresh_done_a, eng_start_a, eng_w_r_a, busy_a, timeout_err_a,
             reg_idx_a} !== 11'd0)
            $display("FAIL rst_mid_outputs: got %b want 0", {wr_ack_a, rd_ack_a, refresh_done_a,
                     eng_start_a, eng_w_r_a, busy_a, timeout_err_a, reg_idx_a});
        else n_pass++;
        repeat (3) @(negedge clk);
        reset_a = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (wa_cyc.size() != bw) $display("FAIL rst_mid_no_ack: got %0d acks want 0", wa_cyc.size() - bw);
        else n_pass++;
        bs = sa_cyc.size();
        @(negedge clk); t1 = cyc; wr_req_a = 1'b1;
        drive_a(200);
        n_checks++;
        if (qat(sa_idx, bs) != 0 || qat(sa_cyc, bs) != t1 + 1 || sa_cyc.size() - bs != 10
            || qat(wa_cyc, bw) != t1 + 41)
            $display("FAIL rst_mid_restart: idx/cycle/count/ack got %0d/%0d/%0d/%0d want 0/%0d/10/%0d",
                     qat(sa_idx, bs), qat(sa_cyc, bs), sa_cyc.size() - bs, qat(wa_cyc, bw),
                     t1 + 1, t1 + 41);
        else n_pass++;
    endtask

    task automatic test_refresh_idle();
        int r0, bs, bw, br, bf;
        bs = sb_cyc.size(); bw = wb_cyc.size(); br = rb_cyc.size(); bf = fb_cyc.size();
        pulse_reset_b(r0);
        wait_until(r0 + 95);
        n_checks++;
        if (qat(sb_cyc, bs) != r0 + 51 || qat(sb_idx, bs) != 9 || qat(sb_wr, bs) != 1)
            $display("FAIL rf_first: cycle/idx/w_r got %0d/%0d/%0d want %0d/9/1",
                     qat(sb_cyc, bs), qat(sb_idx, bs), qat(sb_wr, bs), r0 + 51);
        else n_pass++;
        n_checks++;
        if (qat(sb_idx, bs + 1) != 0 || qat(sb_wr, bs + 1) != 0 || sb_cyc.size() - bs != 10)
            $display("FAIL rf_seq: idx/w_r/count got %0d/%0d/%0d want 0/0/10",
                     qat(sb_idx, bs + 1), qat(sb_wr, bs + 1), sb_cyc.size() - bs);
        else n_pass++;
        n_checks++;
        if (fb_cyc.size() - bf != 1 || qat(fb_cyc, bf) != r0 + 91 || wb_cyc.size() != bw
            || rb_cyc.size() != br)
            $display("FAIL rf_done: count/cycle/user_acks got %0d/%0d/%0d want 1/%0d/0",
                     fb_cyc.size() - bf, qat(fb_cyc, bf), wb_cyc.size() - bw + rb_cyc.size() - br,
                     r0 + 91);
        else n_pass++;
    endtask

    task automatic test_refresh_after_write();
        int r0, bs, bw, bf;
        bs = sb_cyc.size(); bw = wb_cyc.size(); bf = fb_cyc.size();
        pulse_reset_b(r0);
        wait_until(r0 + 44);
        wr_req_b = 1'b1;
        drive_b(200);
        wait_until(r0 + 130);
        n_checks++;
        if (qat(sb_cyc, bs) != r0 + 45 || qat(sb_idx, bs + 9) != 9 || qat(wb_cyc, bw) != r0 + 85)
            $display("FAIL rfw_write: start/last idx/ack got %0d/%0d/%0d want %0d/9/%0d",
                     qat(sb_cyc, bs), qat(sb_idx, bs + 9), qat(wb_cyc, bw), r0 + 45, r0 + 85);
        else n_pass++;
        n_checks++;
        if (qat(sb_cyc, bs + 10) != r0 + 87 || qat(sb_idx, bs + 10) != 9 || qat(sb_wr, bs + 10) != 1)
            $display("FAIL rfw_refresh: cycle/idx/w_r got %0d/%0d/%0d want %0d/9/1",
                     qat(sb_cyc, bs + 10), qat(sb_idx, bs + 10), qat(sb_wr, bs + 10), r0 + 87);
        else n_pass++;
        n_checks++;
        if (qat(fb_cyc, bf) != r0 + 127) $display("FAIL rfw_done: got %0d want %0d",
                                                  qat(fb_cyc, bf), r0 + 127);
        else n_pass++;
    endtask

    task automatic test_read_clears_refresh();
        int r0, bs, br, bf;
        bs = sb_cyc.size(); br = rb_cyc.size(); bf = fb_cyc.size();
        pulse_reset_b(r0);
        wait_until(r0 + 9);
        wr_req_b = 1'b1; rd_req_b = 1'b1;
        drive_b(300);
        wait_until(r0 + 105);
        n_checks++;
        if (qat(sb_cyc, bs + 10) != r0 + 52 || qat(rb_cyc, br) != r0 + 92)
            $display("FAIL rdc_read: start/ack got %0d/%0d want %0d/%0d",
                     qat(sb_cyc, bs + 10), qat(rb_cyc, br), r0 + 52, r0 + 92);
        else n_pass++;
        n_checks++;
        if (qat(sb_cyc, bs + 20) != r0 + 101 || qat(sb_idx, bs + 20) != 9 || fb_cyc.size() != bf)
            $display("FAIL rdc_next_refresh: cycle/idx/rf_dones got %0d/%0d/%0d want %0d/9/0",
                     qat(sb_cyc, bs + 20), qat(sb_idx, bs + 20), fb_cyc.size() - bf, r0 + 101);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_back_to_back();
        test_timeout();
        test_reset_mid_burst();
        test_refresh_idle();
        test_refresh_after_write();
        test_read_clears_refresh();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
